regwrite_arbiter: RTL

Shares the register file's single write port (WE3/A3/WD3) between three writeback requesters: execute result (Ex), load data (Ld) and the debug/program loader (Dbg). It arbitrates with fixed priority plus an aging boost for Dbg, and registers the winning write onto the port. Writes to R15 are diverted to a separate PC-write strobe, because the register file ignores them. It sits between the writeback stage and the register file.

---
 rtl/processor_pkg.sv | 33 +++
 rtl/wb_age_counter.sv | 51 +++++
 rtl/regwrite_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// processor_pkg
// Shared definitions for the writeback / register-file write path:
//   REG_PC   - index of the program counter register (R15)
//   REG_AW   - register address width
//   DATA_W   - register data width
//   req_e    - requester index used by the write-port arbiter
//   arb_state_e - arbiter FSM states
package processor_pkg;

  localparam logic [3:0] REG_PC = 4'd15;
  localparam int         REG_AW = 4;
  localparam int         DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_EX   = 2'd0,
    REQ_LD   = 2'd1,
    REQ_DBG  = 2'd2,
    REQ_NONE = 2'd3
  } req_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_BOOST  = 1'b1
  } arb_state_e;

  // True when two or more of the three requesters are valid at once.
  function automatic logic multi_valid(input logic [2:0] valid);
    logic [1:0] cnt;
    cnt = {1'b0, valid[0]} + {1'b0, valid[1]} + {1'b0, valid[2]};
    return (cnt >= 2'd2);
  endfunction

endpackage

// File: rtl/wb_age_counter.sv
// wb_age_counter
// Tracks how many consecutive cycles the debug requester has been blocked
// and flags starvation once that count reaches STARVE_LIMIT.
// Ports:
//   CLK        in  clock (posedge)
//   Reset      in  synchronous active-high reset
//   dbg_valid  in  Dbg has a write pending
//   dbg_accept in  Dbg write accepted this cycle
//   starved    out age value at the end of this cycle has reached the limit
module wb_age_counter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic CLK,
  input  logic Reset,
  input  logic dbg_valid,
  input  logic dbg_accept,
  output logic starved
);

  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

  logic [7:0] age_r;
  logic [7:0] age_next_s;

  // Next age: cleared when Dbg is idle or served, otherwise counts blocked
  // cycles (saturating so a stuck requester cannot wrap back to zero).
  always_comb begin
    age_next_s = age_r;
    if (!dbg_valid || dbg_accept) begin
      age_next_s = 8'd0;
    end else if (age_r != 8'hFF) begin
      age_next_s = age_r + 8'd1;
    end else begin
      age_next_s = age_r;
    end
  end

  // The compare looks at the next value so the FSM can promote Dbg on the
  // same edge the counter reaches the limit.
  assign starved = (age_next_s >= LIMIT_C);

  // Age register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      age_r <= 8'd0;
    end else begin
      age_r <= age_next_s;
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
// Shares the register file's single write port between the execute result
// (Ex), load data (Ld) and the debug/program loader (Dbg). Fixed priority
// Ex > Ld > Dbg, with Dbg promoted to top priority after STARVE_LIMIT
// consecutive blocked cycles. Writes to R15 go to the PC strobe instead.
// Ports:
//   CLK, Reset                 clock, synchronous active-high reset
//   {Ex,Ld,Dbg}Valid/Ready     per-requester handshake (Ready combinational)
//   {Ex,Ld,Dbg}A3 / WD         per-requester destination and data
//   WE3/A3/WD3                 registered register-file write port
//   PCWE/PCWD                  registered PC write strobe and data
//   ConflictCount              saturating count of multi-requester cycles
//   Boost                      Dbg currently holds promoted priority
// Optional feature macro REGWRITE_ARB_BYPASS_EN adds RA1/RA2 inputs and
// FwdHit1/2, FwdData1/2 outputs for same-cycle read forwarding.
module regwrite_arbiter
  import processor_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ExValid,
  input  logic              LdValid,
  input  logic              DbgValid,
  output logic              ExReady,
  output logic              LdReady,
  output logic              DbgReady,
  input  logic [REG_AW-1:0] ExA3,
  input  logic [REG_AW-1:0] LdA3,
  input  logic [REG_AW-1:0] DbgA3,
  input  logic [DATA_W-1:0] ExWD,
  input  logic [DATA_W-1:0] LdWD,
  input  logic [DATA_W-1:0] DbgWD,
`ifdef REGWRITE_ARB_BYPASS_EN
  input  logic [REG_AW-1:0] RA1,
  input  logic [REG_AW-1:0] RA2,
  output logic              FwdHit1,
  output logic              FwdHit2,
  output logic [DATA_W-1:0] FwdData1,
  output logic [DATA_W-1:0] FwdData2,
`endif
  output logic              WE3,
  output logic [REG_AW-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              PCWE,
  output logic [DATA_W-1:0] PCWD,
  output logic [CNT_W-1:0]  ConflictCount,
  output logic              Boost
);

  arb_state_e        state_r;
  req_e              grant_s;
  logic              accept_s;
  logic [REG_AW-1:0] sel_a3_s;
  logic [DATA_W-1:0] sel_wd_s;
  logic              starved_s;
  logic              conflict_s;

  // Grant selection. Reset suppresses every grant so nothing is accepted
  // during the reset cycle.
  always_comb begin
    grant_s = REQ_NONE;
    if (Reset) begin
      grant_s = REQ_NONE;
    end else if (state_r == ST_BOOST) begin
      if (DbgValid)     grant_s = REQ_DBG;
      else if (ExValid) grant_s = REQ_EX;
      else if (LdValid) grant_s = REQ_LD;
      else              grant_s = REQ_NONE;
    end else begin
      if (ExValid)       grant_s = REQ_EX;
      else if (LdValid)  grant_s = REQ_LD;
      else if (DbgValid) grant_s = REQ_DBG;
      else               grant_s = REQ_NONE;
    end
  end

  assign ExReady  = (grant_s == REQ_EX);
  assign LdReady  = (grant_s == REQ_LD);
  assign DbgReady = (grant_s == REQ_DBG);
  assign accept_s = (grant_s != REQ_NONE);

  // Payload mux for the winning requester.
  always_comb begin
    sel_a3_s = {REG_AW{1'b0}};
    sel_wd_s = {DATA_W{1'b0}};
    case (grant_s)
      REQ_EX: begin
        sel_a3_s = ExA3;
        sel_wd_s = ExWD;
      end
      REQ_LD: begin
        sel_a3_s = LdA3;
        sel_wd_s = LdWD;
      end
      REQ_DBG: begin
        sel_a3_s = DbgA3;
        sel_wd_s = DbgWD;
      end
      default: begin
        sel_a3_s = {REG_AW{1'b0}};
        sel_wd_s = {DATA_W{1'b0}};
      end
    endcase
  end

  assign conflict_s = multi_valid({DbgValid, LdValid, ExValid});

  wb_age_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_age (
    .CLK        (CLK),
    .Reset      (Reset),
    .dbg_valid  (DbgValid),
    .dbg_accept (DbgReady),
    .starved    (starved_s)
  );

  // Write-port / PC-strobe registers. A3 and WD3 only move on a real
  // register write so an R15 write leaves them untouched.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      WE3  <= 1'b0;
      A3   <= {REG_AW{1'b0}};
      WD3  <= {DATA_W{1'b0}};
      PCWE <= 1'b0;
      PCWD <= {DATA_W{1'b0}};
    end else begin
      WE3  <= accept_s && (sel_a3_s != REG_PC);
      PCWE <= accept_s && (sel_a3_s == REG_PC);
      if (accept_s && (sel_a3_s != REG_PC)) begin
        A3  <= sel_a3_s;
        WD3 <= sel_wd_s;
      end else begin
        A3  <= A3;
        WD3 <= WD3;
      end
      if (accept_s && (sel_a3_s == REG_PC)) begin
        PCWD <= sel_wd_s;
      end else begin
        PCWD <= PCWD;
      end
    end
  end

  // Saturating count of cycles with two or more requesters valid.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ConflictCount <= {CNT_W{1'b0}};
    end else if (conflict_s && (ConflictCount != {CNT_W{1'b1}})) begin
      ConflictCount <= ConflictCount + 1'b1;
    end else begin
      ConflictCount <= ConflictCount;
    end
  end

  // Priority FSM. BOOST always grants Dbg if it is still valid, so it lasts
  // at most one cycle per promotion.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= ST_NORMAL;
    end else begin
      case (state_r)
        ST_NORMAL: begin
          if (starved_s) state_r <= ST_BOOST;
          else           state_r <= ST_NORMAL;
        end
        ST_BOOST: begin
          if (!DbgValid || DbgReady) state_r <= ST_NORMAL;
          else                       state_r <= ST_BOOST;
        end
        default: state_r <= ST_NORMAL;
      endcase
    end
  end

  assign Boost = (state_r == ST_BOOST);

`ifdef REGWRITE_ARB_BYPASS_EN
  // R15 never reaches the write port, so it is excluded from forwarding.
  assign FwdHit1  = WE3 & (A3 == RA1) & (RA1 != REG_PC);
  assign FwdHit2  = WE3 & (A3 == RA2) & (RA2 != REG_PC);
  assign FwdData1 = WD3;
  assign FwdData2 = WD3;
`endif

endmodule
